// File: rtl/cmd_queue_arb.sv
// cmd_queue_arb: multi-channel command queue with round-robin head presentation.
// Each channel is a circular buffer. One head command at a time is presented
// to the issuer; that grant holds until it is popped. A sticky drained flag
// reports that every queue has stayed empty, with task completion asserted,
// for DONE_HOLD consecutive cycles.
module cmd_queue_arb #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 16,
  parameter int DONE_HOLD = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rstn,
  input  logic [CHANNELS-1:0]                    i_wr,
  input  logic [CHANNELS*WIDTH-1:0]              i_wr_data,
  output logic [CHANNELS-1:0]                    o_full,
  output logic [CHANNELS-1:0]                    o_ovf,
  output logic [CHANNELS*($clog2(DEPTH)+1)-1:0]  o_count,
  input  logic                                   i_rd,
  output logic [WIDTH-1:0]                       o_cmd,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_chan,
  output logic                                   o_empty,
  input  logic                                   i_task_done,
  output logic                                   o_drained
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int HW = $clog2(DONE_HOLD + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_CNT = HW'(DONE_HOLD);

  // Storage and per-channel bookkeeping
  logic [WIDTH-1:0]    mem_r    [CHANNELS][DEPTH];
  logic [AW-1:0]       rd_ptr_r [CHANNELS];
  logic [AW-1:0]       wr_ptr_r [CHANNELS];
  logic [CW-1:0]       count_r  [CHANNELS];
  logic [CHANNELS-1:0] ovf_r;

  // Grant and arbitration state
  logic          gnt_vld_r;
  logic [GW-1:0] gnt_r;
  logic [GW-1:0] rr_r;

  // Drain tracking
  logic [HW-1:0] drain_cnt_r;
  logic          drained_r;

  // Combinational next-state signals
  logic [CHANNELS-1:0] full_s;
  logic [CHANNELS-1:0] wr_acc_s;
  logic [CHANNELS-1:0] pop_ch_s;
  logic [CW-1:0]       count_next_s [CHANNELS];
  logic                pop_s;
  logic [GW-1:0]       gnt_inc_s;
  logic [GW-1:0]       rr_base_s;
  logic                nxt_vld_s;
  logic [GW-1:0]       nxt_gnt_s;
  logic                all_zero_s;
  logic                drain_qual_s;
  logic [HW-1:0]       drain_next_s;
  logic [WIDTH-1:0]    cmd_s;

  // Per-channel write acceptance, pop decode and post-update occupancy
  always_comb begin
    pop_s = i_rd & gnt_vld_r;
    for (int c = 0; c < CHANNELS; c++) begin
      full_s[c]       = (count_r[c] == FULL_CNT);
      wr_acc_s[c]     = i_wr[c] & ~full_s[c];
      pop_ch_s[c]     = pop_s & (int'(gnt_r) == c);
      count_next_s[c] = count_r[c] + CW'(wr_acc_s[c]) - CW'(pop_ch_s[c]);
    end
  end

  // Round-robin search over post-update counts, starting after a popped channel
  always_comb begin
    int idx;
    idx       = 0;
    gnt_inc_s = (int'(gnt_r) == CHANNELS - 1) ? {GW{1'b0}} : gnt_r + GW'(1);
    rr_base_s = pop_s ? gnt_inc_s : rr_r;
    nxt_vld_s = 1'b0;
    nxt_gnt_s = {GW{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(rr_base_s) + k) % CHANNELS;
      if (!nxt_vld_s && (count_next_s[idx] != {CW{1'b0}})) begin
        nxt_vld_s = 1'b1;
        nxt_gnt_s = GW'(idx);
      end else begin
        nxt_vld_s = nxt_vld_s;
      end
    end
  end

  // Idle qualification and saturating drain counter next value
  always_comb begin
    all_zero_s = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      all_zero_s = all_zero_s & (count_r[c] == {CW{1'b0}});
    end
    drain_qual_s = ~gnt_vld_r & all_zero_s & ~(|i_wr) & i_task_done;
    if (!drain_qual_s) begin
      drain_next_s = {HW{1'b0}};
    end else if (drain_cnt_r == HOLD_CNT) begin
      drain_next_s = HOLD_CNT;
    end else begin
      drain_next_s = drain_cnt_r + HW'(1);
    end
  end

  // Queue storage writes; contents are not cleared by reset
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_acc_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= i_wr_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Pointers, counts, overflow flags, grant and drain state
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_ptr_r[c] <= {AW{1'b0}};
        wr_ptr_r[c] <= {AW{1'b0}};
        count_r[c]  <= {CW{1'b0}};
      end
      ovf_r       <= {CHANNELS{1'b0}};
      gnt_vld_r   <= 1'b0;
      gnt_r       <= {GW{1'b0}};
      rr_r        <= {GW{1'b0}};
      drain_cnt_r <= {HW{1'b0}};
      drained_r   <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_acc_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + AW'(1);
        end
        if (pop_ch_s[c]) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + AW'(1);
        end
        count_r[c] <= count_next_s[c];
        if (i_wr[c] && full_s[c]) begin
          ovf_r[c] <= 1'b1;
        end
      end
      // A presented command stays frozen until the issuer takes it
      if (!gnt_vld_r || pop_s) begin
        gnt_vld_r <= nxt_vld_s;
        gnt_r     <= nxt_gnt_s;
      end
      if (pop_s) begin
        rr_r <= gnt_inc_s;
      end
      drain_cnt_r <= drain_next_s;
      if (|wr_acc_s) begin
        drained_r <= 1'b0;
      end else if (drain_next_s == HOLD_CNT) begin
        drained_r <= 1'b1;
      end
    end
  end

  // Head-of-grant read, forced to zero when nothing is presented
  always_comb begin
    cmd_s = {WIDTH{1'b0}};
    if (gnt_vld_r) begin
      cmd_s = mem_r[gnt_r][rd_ptr_r[gnt_r]];
    end else begin
      cmd_s = {WIDTH{1'b0}};
    end
  end

  // Pack per-channel status onto the output buses
  always_comb begin
    o_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      o_count[c*CW +: CW] = count_r[c];
    end
  end

  assign o_full    = full_s;
  assign o_ovf     = ovf_r;
  assign o_cmd     = cmd_s;
  assign o_chan    = gnt_r;
  assign o_empty   = ~gnt_vld_r;
  assign o_drained = drained_r;

endmodule

// File: doc/cmd_queue_arb.md
# cmd_queue_arb

Parametrised multi-channel command queue that sits between command producers (preload logic, host port, or bench) and the issuer inside `top`. It replaces the single bench-side FIFO and `finished_task` polling loop. It buffers up to `CHANNELS` independent command streams, presents one registered, stable head command at a time to the issuer under round-robin arbitration, and raises a sticky drained flag once every queue is empty and the pool has reported task completion for a programmable hold time.

## Interface
- `WIDTH`, 32: command width in bits (instantiated with `$bits(cmd_t)`).
- `CHANNELS`, 2: number of independent queues, ≥1.
- `DEPTH`, 16: entries per queue, power of two, ≥2.
- `DONE_HOLD`, 4: consecutive cycles of idle + `i_task_done` required before `o_drained` asserts, ≥1.
- `i_clk` in 1: clock; every flop is rising-edge.
- `i_rstn` in 1: asynchronous, active-low reset.
- `i_wr` in CHANNELS: per-channel write strobe.
- `i_wr_data` in CHANNELS*WIDTH: channel c's data at bits [c*WIDTH +: WIDTH].
- `o_full` out CHANNELS: channel c holds DEPTH entries.
- `o_ovf` out CHANNELS: sticky; a write was attempted while full.
- `o_count` out CHANNELS*($clog2(DEPTH)+1): per-channel occupancy.
- `i_rd` in 1: issuer pop of the presented command (same role as `issuer_rd_queue`).
- `o_cmd` out WIDTH: head of the granted channel; 0 when `o_empty`.
- `o_chan` out max(1,$clog2(CHANNELS)): granted channel index.
- `o_empty` out 1: no command presented.
- `i_task_done` in 1: `finished_task` from the pool.
- `o_drained` out 1: sticky completion flag.

## Operation
- Each channel is a circular buffer with its own read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- A write on channel c with `o_full[c]`=1 is dropped and sets `o_ovf[c]`. This holds even if the same channel is popped in that cycle. `o_full` is decoded from the current count.
- Grant register: `r_gnt_vld`, `r_gnt`, plus round-robin pointer `r_rr`.
- Next-grant computation uses post-update counts (`count_next`) and selects the first channel with `count_next` ≠ 0, searching from `r_rr` upward with wrap.
- While `r_gnt_vld`=1 and `i_rd`=0, the grant is frozen. `o_cmd` and `o_chan` must not change, even if writes land on other channels.
- With `r_gnt_vld`=0, the grant loads every cycle from the next-grant computation.
- On `i_rd`=1 with `r_gnt_vld`=1:
  - pop channel `r_gnt`;
  - set `r_rr` to `r_gnt`+1 mod CHANNELS;
  - reload the grant using the updated `r_rr` and `count_next`, so back-to-back pops are sustained at 1 per cycle.
- `i_rd` with `o_empty`=1 is ignored.
- Simultaneous write and pop on the same channel: both take effect, and the count is unchanged.
- `o_empty` = !`r_gnt_vld`. `o_cmd` = memory[`r_gnt`][rdptr], forced to 0 when `o_empty`=1.
- Drain counter, saturating at DONE_HOLD:
  - increments each cycle that `o_empty`=1, all counts are 0, no `i_wr` bit is set, and `i_task_done`=1;
  - otherwise clears to 0.
- `o_drained` sets when the counter reaches DONE_HOLD. It clears only on the next accepted write or on reset.
- Reset mid-operation: all pointers, counts, grant, `r_rr`, the drain counter and flags are cleared asynchronously. Queue contents are discarded (memory need not be cleared).

## Timing
- Reset values: `o_full`=0, `o_ovf`=0, `o_count`=0, `o_cmd`=0, `o_chan`=0, `o_empty`=1, `o_drained`=0.
- Write-to-present latency is 1 cycle. A write sampled at edge k into an idle block gives `o_empty`=0 and a valid `o_cmd` after edge k.
- Pop-to-next latency is 0 bubbles. With `i_rd` held high and data available, one command is consumed per cycle.
- `o_count`, `o_full` and `o_ovf` update at the edge that samples the write or pop.
- `o_drained` rises DONE_HOLD edges after the first qualifying cycle is sampled.

## Test plan
- Reset, then write 0xA1 on ch0 at edge 1 → after edge 1: `o_empty`=0, `o_cmd`=0xA1, `o_chan`=0. Pop at edge 2 → `o_empty`=1, `o_cmd`=0.
- CHANNELS=2: preload ch0 with {1,2,3} and ch1 with {11,12}, then hold `i_rd`=1 → pops occur on consecutive cycles in order 1,11,2,12,3, then `o_empty`=1.
- Grant stability: ch1 presenting 5 with `i_rd`=0, write 7 into empty ch0 with `r_rr`=0 → `o_cmd` stays 5 and `o_chan` stays 1 until popped, then 7 is presented.
- DEPTH=4: write 5 entries to ch0 with no pop → `o_full[0]`=1 after the 4th, 5th write dropped, `o_ovf[0]`=1, `o_count` ch0=4. Pop+write on a full ch0 in the same cycle → write dropped, count=3.
- Drain: queues empty, `i_task_done`=1 for 3 cycles, drops for 1, then high for 4 (DONE_HOLD=4) → `o_drained` rises only after the 4th consecutive cycle. A subsequent write clears it.
- Assert `i_rstn`=0 asynchronously mid-burst with ch1 count 3 → outputs take reset values immediately. After release, pops produce nothing until a new write.
